// File: rtl/md_sched.sv
// Multiply/divide scheduler for the E stage: owns HI/LO, runs MULT/DIV ops as multi-cycle jobs.
// Latency: MUL_CYCLES (MULT/MULTU) or DIV_CYCLES (DIV/DIVU) busy cycles after start; MFHI/MFLO are zero-latency.
// Backpressure: no queueing; stall_md asks the hazard unit to hold D while an MD op is starting or running.
module md_sched #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_use_D,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] md_rdata_E,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [31:0] r_hi, r_lo;
    logic        r_busy;
    logic        w_commit;
    logic        w_is_arith;

    // Arithmetic datapath, always fed from the latched operands.
    logic [63:0] w_smul, w_umul;
    logic        w_b_zero, w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_quot, w_rem;
    logic [31:0] w_res_hi, w_res_lo;

    assign w_is_arith = (md_op_E >= OP_MULT) && (md_op_E <= OP_DIVU);
    assign start      = w_is_arith && (r_state == S_IDLE);
    assign busy       = r_busy;
    assign stall_md   = md_use_D && (start || r_busy);
    assign hi         = r_hi;
    assign lo         = r_lo;

    assign w_smul   = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_umul   = {32'd0, r_a} * {32'd0, r_b};
    // Signed divide done on magnitudes so the quotient truncates toward zero
    // and the remainder takes the dividend's sign; a zero divisor is replaced
    // by 1 only to keep the datapath X-free, its result is never committed.
    assign w_b_zero = (r_b == 32'd0);
    assign w_a_neg  = (r_op == OP_DIV) && r_a[31];
    assign w_b_neg  = (r_op == OP_DIV) && r_b[31];
    assign w_a_mag  = w_a_neg ? (-r_a) : r_a;
    assign w_b_mag  = w_b_zero ? 32'd1 : (w_b_neg ? (-r_b) : r_b);
    assign w_q_mag  = w_a_mag / w_b_mag;
    assign w_r_mag  = w_a_mag % w_b_mag;
    assign w_quot   = (w_a_neg ^ w_b_neg) ? (-w_q_mag) : w_q_mag;
    assign w_rem    = w_a_neg ? (-w_r_mag) : w_r_mag;

    // Select the result pair for the latched op.
    always_comb begin
        w_res_hi = w_rem;
        w_res_lo = w_quot;
        case (r_op)
            OP_MULT:  {w_res_hi, w_res_lo} = w_smul;
            OP_MULTU: {w_res_hi, w_res_lo} = w_umul;
            default:  begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
            end
        endcase
    end

    // Next-state logic: IDLE launches on start, RUN counts down and commits at cnt==1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = ((md_op_E == OP_MULT) || (md_op_E == OP_MULTU)) ? MUL_LOAD : DIV_LOAD;
                end
            end
            S_RUN: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State, counter, busy flag and operand latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_op    <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            if (start) begin
                r_op <= md_op_E;
                r_a  <= rs_E;
                r_b  <= rt_E;
            end
        end
    end

    // HI/LO: arithmetic commit (skipped on divide-by-zero) or MTHI/MTLO while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            if (!(((r_op == OP_DIV) || (r_op == OP_DIVU)) && w_b_zero)) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else if (r_state == S_IDLE) begin
            if (md_op_E == OP_MTHI) r_hi <= rs_E;
            if (md_op_E == OP_MTLO) r_lo <= rs_E;
        end
    end

    // Zero-latency HI/LO read port; anything other than MFHI/MFLO reads 0.
    always_comb begin
        md_rdata_E = 32'd0;
        case (md_op_E)
            OP_MFHI: md_rdata_E = r_hi;
            OP_MFLO: md_rdata_E = r_lo;
            default: md_rdata_E = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: directed ops, expected HI/LO/busy-length queued per op,
// a negedge monitor pops one entry each time busy falls and compares.
module tb_md_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  md_op_E;
    logic [31:0] rs_E, rt_E;
    logic        md_use_D;
    logic        start, busy, stall_md;
    logic [31:0] md_rdata_E, hi, lo;

    md_sched #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .md_op_E    (md_op_E),
        .rs_E       (rs_E),
        .rt_E       (rt_E),
        .md_use_D   (md_use_D),
        .start      (start),
        .busy       (busy),
        .stall_md   (stall_md),
        .md_rdata_E (md_rdata_E),
        .hi         (hi),
        .lo         (lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;
    int   run_len = 0;
    logic prev_busy = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: count busy/stall cycles, and on each busy fall compare against the queue head.
    always @(negedge clk) begin
        if (stall_md === 1'b1) stall_cnt++;
        if (busy === 1'b1) run_len++;
        if (prev_busy === 1'b1 && busy !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_completion", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("commit_hi", hi, e.hi);
                check("commit_lo", lo, e.lo);
                check("busy_len", 32'(run_len), 32'(e.len));
            end
            run_len = 0;
        end
        prev_busy = busy;
    end

    task automatic push_exp(input logic [31:0] h, input logic [31:0] l, input int n);
        exp_t e;
        e.hi = h; e.lo = l; e.len = n;
        exp_q.push_back(e);
    endtask

    // Called at posedge+#1: present op for one cycle, check start, leave E bubbled.
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op_E = op; rs_E = a; rt_E = b;
        #1;
        check("start_hi", 32'(start), 32'd1);
        @(posedge clk); #1;
        md_op_E = 4'd0; rs_E = 32'd0; rt_E = 32'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) check("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; md_op_E = 4'd0; rs_E = 32'd0; rt_E = 32'd0; md_use_D = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_stall", 32'(stall_md), 32'd0);
        check("rst_rdata", md_rdata_E, 32'd0);
        step();

        // MULT -3*5 with D using MD: stall spans start cycle + 5 busy cycles.
        stall_cnt = 0;
        md_use_D = 1'b1;
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
        start_op(4'd1, 32'hFFFF_FFFD, 32'd5);
        wait_idle();
        #1;
        check("stall_during", 32'(stall_cnt), 32'd6);
        check("stall_after", 32'(stall_md), 32'd0);
        md_use_D = 1'b0;

        // MULTU without D usage: no stall at all.
        stall_cnt = 0;
        push_exp(32'h0000_0001, 32'hFFFF_FFFE, 5);
        start_op(4'd2, 32'hFFFF_FFFF, 32'd2);
        wait_idle();
        check("stall_none", 32'(stall_cnt), 32'd0);
        md_op_E = 4'd6; #1;
        check("mflo", md_rdata_E, 32'hFFFF_FFFE);
        md_op_E = 4'd5; #1;
        check("mfhi", md_rdata_E, 32'h0000_0001);
        md_op_E = 4'd9; #1;
        check("undef_rdata", md_rdata_E, 32'd0);
        check("undef_start", 32'(start), 32'd0);
        md_op_E = 4'd0;
        step();

        // DIV -7/2 then DIVU of the same bits.
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        start_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        push_exp(32'h0000_0001, 32'h7FFF_FFFC, 10);
        start_op(4'd4, 32'hFFFF_FFF9, 32'd2);
        wait_idle();

        // MTHI/MTLO while idle: visible the following cycle.
        md_op_E = 4'd7; rs_E = 32'h11;
        step();
        check("mthi", hi, 32'h11);
        md_op_E = 4'd8; rs_E = 32'h22;
        step();
        check("mtlo", lo, 32'h22);
        md_op_E = 4'd5; rs_E = 32'd0; #1;
        check("mfhi_after_mt", md_rdata_E, 32'h11);
        md_op_E = 4'd0;
        step();

        // DIVU by zero: full duration, HI/LO untouched; MTHI and MULT while busy are dropped.
        push_exp(32'h11, 32'h22, 10);
        start_op(4'd4, 32'd7, 32'd0);
        md_op_E = 4'd7; rs_E = 32'hAB;
        step();
        check("mthi_busy", hi, 32'h11);
        md_op_E = 4'd1; rs_E = 32'd5; rt_E = 32'd5; #1;
        check("start_busy", 32'(start), 32'd0);
        step();
        md_op_E = 4'd0; rs_E = 32'd0; rt_E = 32'd0;
        wait_idle();

        // Reset in busy cycle 3 of a DIV aborts it; then MULT 2*3 runs cleanly.
        push_exp(32'd0, 32'd0, 3);
        start_op(4'd3, 32'd100, 32'd7);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        push_exp(32'd0, 32'd6, 5);
        start_op(4'd1, 32'd2, 32'd3);
        wait_idle();

        repeat (2) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
